// File: rtl/hazard_ctrl.sv
// hazard_ctrl: sequencing controller for the 5-stage MIPS pipeline.
// It inserts load-use bubbles, flushes the front end on a taken branch, and
// freezes the pipeline while data memory is busy. It also keeps a saturating
// stall-cycle counter and a sticky memory-timeout flag.
module hazard_ctrl #(
    parameter int AWIDTH   = 5,
    parameter int LU_STALL = 1,
    parameter int TIMEOUT  = 16,
    parameter int CWIDTH   = 16
) (
    input  logic              h_clk,
    input  logic              h_rst,
    input  logic              h_i_ce,
    input  logic              h_i_id_valid,
    input  logic [AWIDTH-1:0] h_i_id_rs,
    input  logic [AWIDTH-1:0] h_i_id_rt,
    input  logic              h_i_id_uses_rt,
    input  logic              h_i_ex_memread,
    input  logic [AWIDTH-1:0] h_i_ex_rd,
    input  logic              h_i_ex_branch,
    input  logic              h_i_ex_taken,
    input  logic              h_i_mem_busy,
    output logic              h_o_pc_we,
    output logic              h_o_pc_sel,
    output logic              h_o_ifid_we,
    output logic              h_o_ifid_flush,
    output logic              h_o_idex_flush,
    output logic              h_o_back_we,
    output logic [CWIDTH-1:0] h_o_stall_cnt,
    output logic              h_o_timeout
);

    // busy_cnt only needs to reach TIMEOUT, where it saturates
    localparam int BWIDTH = $clog2(TIMEOUT + 1);
    localparam logic [BWIDTH-1:0] BUSY_MAX = BWIDTH'(TIMEOUT);
    localparam logic [1:0]        LU_INIT  = 2'(LU_STALL - 1);

    typedef enum logic {S_RUN, S_STALL} state_t;

    state_t             r_state;
    logic [1:0]         r_lu_cnt;
    logic [BWIDTH-1:0]  r_busy_cnt;
    logic [CWIDTH-1:0]  r_stall_cnt;
    logic               r_timeout;

    logic               w_haz;
    logic               w_taken;

    function automatic logic [CWIDTH-1:0] sat_inc(input logic [CWIDTH-1:0] v);
        return (&v) ? v : v + CWIDTH'(1);
    endfunction

    // A load in EX whose destination is read by the ID instruction; $0 never hazards
    assign w_haz = h_i_id_valid & h_i_ex_memread & (h_i_ex_rd != '0) &
                   ((h_i_ex_rd == h_i_id_rs) | (h_i_id_uses_rt & (h_i_ex_rd == h_i_id_rt)));
    assign w_taken = h_i_ex_branch & h_i_ex_taken;

    assign h_o_stall_cnt = r_stall_cnt;
    assign h_o_timeout   = r_timeout;

    // Pipeline control strobes, decoded by priority: reset, hold, freeze, stall, branch, hazard
    always_comb begin
        h_o_pc_we      = 1'b0;
        h_o_pc_sel     = 1'b0;
        h_o_ifid_we    = 1'b0;
        h_o_ifid_flush = 1'b0;
        h_o_idex_flush = 1'b0;
        h_o_back_we    = 1'b0;
        if (h_rst) begin
            h_o_ifid_flush = 1'b1;
            h_o_idex_flush = 1'b1;
        end else if (!h_i_ce || h_i_mem_busy) begin
            // everything frozen: all strobes stay low
        end else if (r_state == S_STALL) begin
            // EX holds a bubble here, so the EX-stage inputs are ignored
            h_o_idex_flush = 1'b1;
            h_o_back_we    = 1'b1;
        end else if (w_taken) begin
            // the younger instructions, including any hazarding one, are squashed
            h_o_pc_we      = 1'b1;
            h_o_pc_sel     = 1'b1;
            h_o_ifid_we    = 1'b1;
            h_o_ifid_flush = 1'b1;
            h_o_idex_flush = 1'b1;
            h_o_back_we    = 1'b1;
        end else if (w_haz) begin
            h_o_idex_flush = 1'b1;
            h_o_back_we    = 1'b1;
        end else begin
            h_o_pc_we      = 1'b1;
            h_o_ifid_we    = 1'b1;
            h_o_back_we    = 1'b1;
        end
    end

    // Stall FSM, bubble countdown, freeze/timeout tracking and stall statistics
    always_ff @(posedge h_clk) begin
        if (h_rst) begin
            r_state     <= S_RUN;
            r_lu_cnt    <= 2'd0;
            r_busy_cnt  <= '0;
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else if (h_i_ce) begin
            if (h_i_mem_busy) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
                if (r_busy_cnt != BUSY_MAX) begin
                    r_busy_cnt <= r_busy_cnt + BWIDTH'(1);
                end
                // this edge closes the TIMEOUT-th consecutive busy cycle (or a later one)
                if (r_busy_cnt >= BUSY_MAX - BWIDTH'(1)) begin
                    r_timeout <= 1'b1;
                end
            end else begin
                r_busy_cnt <= '0;
                if (r_state == S_STALL) begin
                    r_stall_cnt <= sat_inc(r_stall_cnt);
                    r_lu_cnt    <= r_lu_cnt - 2'd1;
                    if (r_lu_cnt == 2'd1) begin
                        r_state <= S_RUN;
                    end
                end else if (w_taken) begin
                    // branch redirect is not a stall
                end else if (w_haz) begin
                    r_stall_cnt <= sat_inc(r_stall_cnt);
                    if (LU_STALL > 1) begin
                        r_state  <= S_STALL;
                        r_lu_cnt <= LU_INIT;
                    end
                end
            end
        end
    end

endmodule
